// File: rtl/maple_frame_receiver_if.sv
// Maple receiver bus bundle: the two raw controller lines and enable into the
// receiver, plus the decoded byte stream and frame status back out.
//   controller_pin1 / controller_pin5 : raw SDCKA / SDCKB, asynchronous
//   enable                            : permit new start patterns
//   data / data_valid                 : received byte and its one-cycle strobe
//   frame_start / frame_done          : one-cycle frame boundary strobes
//   byte_count / crc_ok / error_code  : frame status, valid from frame_done
// slave is the receiver side, master is the side driving the lines.
interface maple_frame_receiver_if #(
   parameter int COUNT_W = 11
);
   logic               controller_pin1;
   logic               controller_pin5;
   logic               enable;
   logic [7:0]         data;
   logic               data_valid;
   logic               frame_start;
   logic               frame_done;
   logic [COUNT_W-1:0] byte_count;
   logic               crc_ok;
   logic [1:0]         error_code;

   modport slave (
      input  controller_pin1, controller_pin5, enable,
      output data, data_valid, frame_start, frame_done,
             byte_count, crc_ok, error_code
   );

   modport master (
      output controller_pin1, controller_pin5, enable,
      input  data, data_valid, frame_start, frame_done,
             byte_count, crc_ok, error_code
   );
endinterface

// File: rtl/maple_frame_receiver.sv
// Oversampled Dreamcast Maple bus frame receiver. Both bus lines are
// synchronized to clock; falling edges of the synchronized lines drive a
// start / two-phase data / end decoder. Bytes are assembled MSB first and
// streamed out with a strobe; each frame ends with a status report.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : maple_frame_receiver_if.slave (lines in, byte stream and status out)
module maple_frame_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int MAX_BYTES      = 1028,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int COUNT_W        = 11
) (
   input logic                   clock,
   input logic                   reset,
   maple_frame_receiver_if.slave bus
);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, START, DATA_A, DATA_B, DONE} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] sync1, sync5;
   logic                   prev1, prev5;
   logic                   s1, s5, fall1, fall5, any_event;

   logic [IDLE_W-1:0]  idle_cnt;
   logic [2:0]         start_cnt;
   logic [2:0]         bit_cnt;
   logic               timeout;

   logic               accept, commit, latch_prov;
   logic [1:0]         fsm_err;

   logic               prov;
   logic [7:0]         shift;
   logic [7:0]         byte_p0;
   logic               vld_p0;

   logic [COUNT_W-1:0] frame_bytes;
   logic [7:0]         chk;
   logic [1:0]         err;
   logic               overflow;

   logic [7:0]         data_r;
   logic               data_valid_r, frame_start_r, frame_done_r, crc_ok_r;
   logic [COUNT_W-1:0] byte_count_r;
   logic [1:0]         error_code_r;

   // Start-pulse counter saturates so a long burst can never wrap back to 4.
   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   // ---- synchronizer and falling-edge detect ----
   // Idle bus level is high, so reset the chains high to avoid a false edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '1;
         sync5 <= '1;
         prev1 <= 1'b1;
         prev5 <= 1'b1;
      end else begin
         sync1 <= {sync1[SYNC_STAGES-2:0], bus.controller_pin1};
         sync5 <= {sync5[SYNC_STAGES-2:0], bus.controller_pin5};
         prev1 <= s1;
         prev5 <= s5;
      end
   end

   assign s1        = sync1[SYNC_STAGES-1];
   assign s5        = sync5[SYNC_STAGES-1];
   assign fall1     = prev1 & ~s1;
   assign fall5     = prev5 & ~s5;
   assign any_event = fall1 | fall5;
   assign timeout   = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) && !any_event;
   assign overflow  = vld_p0 && (frame_bytes == COUNT_W'(MAX_BYTES));

   // ---- frame decoder ----
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      commit     = 1'b0;
      latch_prov = 1'b0;
      fsm_err    = 2'd0;
      case (state)
         IDLE: begin
            if (bus.enable && !s1 && s5) state_next = START;
         end
         START: begin
            if (s1) begin
               if (start_cnt == 3'd4) begin
                  accept     = 1'b1;
                  state_next = DATA_A;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         DATA_A: begin
            // Any pin5 fall here (alone or together with pin1) is a collision.
            if (fall5) begin
               fsm_err    = 2'd2;
               state_next = DONE;
            end else if (fall1) begin
               latch_prov = 1'b1;
               state_next = DATA_B;
            end else if (timeout) begin
               fsm_err    = 2'd2;
               state_next = DONE;
            end
         end
         DATA_B: begin
            if (fall1 && fall5) begin
               fsm_err    = 2'd2;
               state_next = DONE;
            end else if (fall5) begin
               commit     = 1'b1;
               state_next = DATA_A;
            end else if (fall1) begin
               // Second pin1 fall with pin5 low is the end pattern; the
               // provisional bit is dropped. Pin5 high here is not a legal
               // pattern and is treated as a collision.
               state_next = DONE;
               if (s5)                  fsm_err = 2'd2;
               else if (bit_cnt != 3'd0) fsm_err = 2'd1;
            end else if (timeout) begin
               fsm_err    = 2'd2;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---- bit assembly (p0: completed byte) ----
   always_ff @(posedge clock) begin
      if (latch_prov) prov <= s5;
      if (commit) begin
         shift   <= {shift[5:0], prov, s1};
         byte_p0 <= {shift[5:0], prov, s1};
      end
   end

   // ---- control, counters and output stage (p1: emitted byte, status) ----
   always_ff @(posedge clock) begin
      if (reset) begin
         idle_cnt      <= '0;
         start_cnt     <= 3'd0;
         bit_cnt       <= 3'd0;
         vld_p0        <= 1'b0;
         frame_bytes   <= '0;
         chk           <= 8'h00;
         err           <= 2'd0;
         data_r        <= 8'h00;
         data_valid_r  <= 1'b0;
         frame_start_r <= 1'b0;
         frame_done_r  <= 1'b0;
         byte_count_r  <= '0;
         crc_ok_r      <= 1'b0;
         error_code_r  <= 2'd0;
      end else begin
         if ((state == DATA_A || state == DATA_B) && !any_event)
            idle_cnt <= idle_cnt + IDLE_W'(1);
         else
            idle_cnt <= '0;

         if (state != START) start_cnt <= 3'd0;
         else if (fall5)     start_cnt <= sat_inc3(start_cnt);

         frame_start_r <= accept;
         frame_done_r  <= (state == DONE);
         data_valid_r  <= 1'b0;
         vld_p0        <= commit && (bit_cnt == 3'd6);

         if (accept)      bit_cnt <= 3'd0;
         else if (commit) bit_cnt <= (bit_cnt == 3'd6) ? 3'd0 : bit_cnt + 3'd2;

         if (accept) begin
            frame_bytes <= '0;
            chk         <= 8'h00;
         end else if (vld_p0 && !overflow) begin
            data_r       <= byte_p0;
            data_valid_r <= 1'b1;
            frame_bytes  <= frame_bytes + COUNT_W'(1);
            chk          <= chk ^ byte_p0;
         end

         // First error in a frame wins.
         if (accept)             err <= 2'd0;
         else if (err == 2'd0) begin
            if (overflow)               err <= 2'd3;
            else if (fsm_err != 2'd0)   err <= fsm_err;
         end

         if (state == DONE) begin
            byte_count_r <= frame_bytes;
            error_code_r <= err;
            crc_ok_r     <= (chk == 8'h00) && (frame_bytes != '0) && (err == 2'd0);
         end
      end
   end

   assign bus.data        = data_r;
   assign bus.data_valid  = data_valid_r;
   assign bus.frame_start = frame_start_r;
   assign bus.frame_done  = frame_done_r;
   assign bus.byte_count  = byte_count_r;
   assign bus.crc_ok      = crc_ok_r;
   assign bus.error_code  = error_code_r;
endmodule

// File: tb/tb_maple_frame_receiver.sv
// Scoreboard bench for maple_frame_receiver: the line driver pushes expected
// bytes and frame reports as it drives the bus; a negedge monitor pops and
// compares whenever the receiver strobes data_valid or frame_done.
module tb_maple_frame_receiver;
   localparam int SYNC_STAGES    = 2;
   localparam int MAX_BYTES      = 4;
   localparam int TIMEOUT_CYCLES = 200;
   localparam int COUNT_W        = 11;
   localparam int HALF           = 6;

   typedef struct {
      int         cnt;
      logic       crc;
      logic [1:0] err;
   } frame_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   maple_frame_receiver_if #(.COUNT_W(COUNT_W)) bus();

   maple_frame_receiver #(
      .SYNC_STAGES(SYNC_STAGES),
      .MAX_BYTES(MAX_BYTES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .COUNT_W(COUNT_W)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_fall5_cyc = 0;
   int done_cyc       = -1;
   int starts_seen    = 0;
   int starts_exp     = 0;

   logic [7:0] exp_bytes[$];
   frame_t     exp_frames[$];

   int         m_cnt;
   logic [7:0] m_xor;
   logic [1:0] m_err;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---- monitor ----
   always @(negedge clock) begin
      logic [7:0] b;
      frame_t     f;
      if (bus.data_valid) begin
         if (exp_bytes.size() == 0) begin
            check_val("extra_valid", 32'(bus.data_valid), 32'd0);
         end else begin
            b = exp_bytes.pop_front();
            check_val("data", 32'(bus.data), 32'(b));
            check_val("valid_lat", 32'(cyc - last_fall5_cyc), 32'(SYNC_STAGES + 2));
         end
      end
      if (bus.frame_start) starts_seen++;
      if (bus.frame_done) begin
         done_cyc = cyc;
         if (exp_frames.size() == 0) begin
            check_val("extra_done", 32'(bus.frame_done), 32'd0);
         end else begin
            f = exp_frames.pop_front();
            check_val("byte_count", 32'(bus.byte_count), 32'(f.cnt));
            check_val("crc_ok", 32'(bus.crc_ok), 32'(f.crc));
            check_val("error_code", 32'(bus.error_code), 32'(f.err));
         end
      end
   end

   // ---- driver and model ----
   task automatic drive(input logic p1, input logic p5);
      bus.controller_pin1 = p1;
      bus.controller_pin5 = p5;
      repeat (HALF) @(negedge clock);
   endtask

   task automatic send_start(input int pulses);
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b1);
      for (int i = 0; i < pulses; i++) begin
         drive(1'b0, 1'b0);
         if (i != pulses - 1) drive(1'b0, 1'b1);
      end
      if (bus.enable && pulses == 4) begin
         starts_exp++;
         m_cnt = 0;
         m_xor = 8'h00;
         m_err = 2'd0;
      end
      drive(1'b1, 1'b0);
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 7; i > 7 - n; i -= 2) begin
         drive(1'b1, v[i]);
         drive(1'b0, v[i]);
         if (i - 1 > 7 - n) begin
            drive(v[i-1], 1'b1);
            last_fall5_cyc = cyc;
            drive(v[i-1], 1'b0);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      if (m_cnt < MAX_BYTES) begin
         exp_bytes.push_back(b);
         m_cnt++;
         m_xor = m_xor ^ b;
      end else if (m_err == 2'd0) begin
         m_err = 2'd3;
      end
      send_bits(b, 8);
   endtask

   task automatic push_frame();
      frame_t f;
      f.cnt = m_cnt;
      f.crc = (m_xor == 8'h00) && (m_cnt != 0) && (m_err == 2'd0);
      f.err = m_err;
      exp_frames.push_back(f);
   endtask

   task automatic send_end(input logic partial);
      if (partial && m_err == 2'd0) m_err = 2'd1;
      push_frame();
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      repeat (10) @(negedge clock);
   endtask

   task automatic check_reset_values();
      check_val("rst_data", 32'(bus.data), 32'd0);
      check_val("rst_valid", 32'(bus.data_valid), 32'd0);
      check_val("rst_start", 32'(bus.frame_start), 32'd0);
      check_val("rst_done", 32'(bus.frame_done), 32'd0);
      check_val("rst_count", 32'(bus.byte_count), 32'd0);
      check_val("rst_crc", 32'(bus.crc_ok), 32'd0);
      check_val("rst_err", 32'(bus.error_code), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.controller_pin1 = 1'b1;
      bus.controller_pin5 = 1'b1;
      bus.enable          = 1'b1;
      m_cnt = 0;
      m_xor = 8'h00;
      m_err = 2'd0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_values();

      // good frame
      send_start(4);
      send_byte(8'h0C); send_byte(8'h01); send_byte(8'h20); send_byte(8'h2D);
      send_end(1'b0);

      // bad checksum
      send_start(4);
      send_byte(8'h0C); send_byte(8'h01); send_byte(8'h20); send_byte(8'h2C);
      send_end(1'b0);

      // short start pattern ignored, then a valid frame
      send_start(3);
      drive(1'b1, 1'b1);
      send_start(4);
      send_byte(8'hA5); send_byte(8'hA5);
      send_end(1'b0);

      // one byte plus three bits
      send_start(4);
      send_byte(8'h5A);
      send_bits(8'hC0, 3);
      send_end(1'b1);

      // stall after two bytes
      send_start(4);
      send_byte(8'h11); send_byte(8'h22);
      m_err = 2'd2;
      push_frame();
      done_cyc = -1;
      repeat (TIMEOUT_CYCLES + 20) @(negedge clock);
      check_val("timeout_lat", 32'(done_cyc - last_fall5_cyc),
                32'(TIMEOUT_CYCLES + SYNC_STAGES + 2));
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);

      // overflow: six bytes with four allowed
      send_start(4);
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      send_end(1'b0);

      // reset three bits into a frame
      send_start(4);
      send_bits(8'hE0, 3);
      drive(1'b1, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_reset_values();
      send_start(4);
      send_byte(8'h3C); send_byte(8'h3C);
      send_end(1'b0);

      // simultaneous falls in DATA_A
      send_start(4);
      m_err = 2'd2;
      push_frame();
      drive(1'b1, 1'b1);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      repeat (10) @(negedge clock);

      // start pattern with enable low is ignored
      bus.enable = 1'b0;
      send_start(4);
      drive(1'b1, 1'b1);
      bus.enable = 1'b1;
      repeat (20) @(negedge clock);

      check_val("bytes_left", 32'(exp_bytes.size()), 32'd0);
      check_val("frames_left", 32'(exp_frames.size()), 32'd0);
      check_val("starts", 32'(starts_seen), 32'(starts_exp));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
